mem_req_arbiter: RTL

Shares one single-port req/gnt/rvalid data memory model between N_REQ requesters, for example the instruction-fetch and LSU ports of one core, or two cores run side by side for contract checking.
- Round-robin arbitration; one transaction in flight at a time.
- Registered request issue to the memory.
- Responses are steered back to the requester that owns the transaction.
- A response timeout completes a stalled transaction with an error so the bench never hangs.

---
 rtl/mem_req_arbiter_pkg.sv | 20 ++
 rtl/mem_req_arbiter_rr_pick.sv | 29 ++
 rtl/mem_req_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and width helpers for the memory request arbiter.
package mem_req_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

    // Byte-enable width for a given data width (BE_W).
    function automatic int unsigned be_w(int unsigned data_w);
        return data_w / 8;
    endfunction

    // Owner index width; at least one bit so a single requester still has an index.
    function automatic int unsigned owner_w(int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = owner_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int unsigned cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr) + i) % N;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between N_REQ requesters,
// one transaction in flight, with a response timeout that forces an error completion.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_REQ-1:0]               req_i,
    input  logic [N_REQ-1:0]               req_we_i,
    input  logic [N_REQ*(DATA_W/8)-1:0]    req_be_i,
    input  logic [N_REQ*ADDR_W-1:0]        req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]        req_wdata_i,
    output logic [N_REQ-1:0]               gnt_o,
    output logic [N_REQ-1:0]               rvalid_o,
    output logic [DATA_W-1:0]              rdata_o,
    output logic [N_REQ-1:0]               err_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [DATA_W/8-1:0]            mem_be_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [DATA_W-1:0]              mem_wdata_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    input  logic [DATA_W-1:0]              mem_rdata_i,
    input  logic                           mem_err_i,
    output logic                           busy_o,
    output logic                           stray_o
);

    localparam int unsigned BE_W  = be_w(DATA_W);
    localparam int unsigned IDX_W = owner_w(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [BE_W-1:0]  be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic             stray_q;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             in_txn, done, tmo, win;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign in_txn = (state_q != IDLE);
    assign win    = (state_q == IDLE) && pick_valid;
    assign done   = ((state_q == ISSUE) && mem_gnt_i && mem_rvalid_i) ||
                    ((state_q == RESP) && mem_rvalid_i);
    // A real completion on the last allowed cycle beats the timeout.
    assign tmo    = in_txn && !done && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE: begin
                if (done || tmo)    state_d = IDLE;
                else if (mem_gnt_i) state_d = RESP;
            end
            RESP:    if (done || tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (win) begin
                owner_q <= pick_idx;
                we_q    <= req_we_i[pick_idx];
                be_q    <= req_be_i[pick_idx*BE_W +: BE_W];
                addr_q  <= req_addr_i[pick_idx*ADDR_W +: ADDR_W];
                wdata_q <= req_wdata_i[pick_idx*DATA_W +: DATA_W];
                ptr_q   <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                cnt_q   <= '0;
            end else if (in_txn) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if ((state_q == IDLE) && mem_rvalid_i) stray_q <= 1'b1;
        end
    end

    assign mem_req_o   = (state_q == ISSUE);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = in_txn;
    assign stray_o     = stray_q;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        if (state_q == ISSUE) gnt_o[owner_q] = mem_gnt_i | tmo;
        if (in_txn) begin
            rvalid_o[owner_q] = mem_rvalid_i | tmo;
            err_o[owner_q]    = tmo | mem_err_i;
            if (mem_rvalid_i && !tmo) rdata_o = mem_rdata_i;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) $onehot0(gnt_o));
    a_rvalid_onehot0: assert property (@(posedge clk_i) $onehot0(rvalid_o));
    a_mem_stable: assert property (@(posedge clk_i)
        (mem_req_o && !mem_gnt_i && !rst_i) |=>
        ($stable(mem_addr_o) && $stable(mem_we_o) && $stable(mem_be_o) && $stable(mem_wdata_o)));
    a_grant_requested: assert property (@(posedge clk_i)
        (win && !rst_i) |-> req_i[pick_idx]);

endmodule
